// File: rtl/wk_fetch.sv
// wk_fetch: streams the K-projection weight region out of a read-only memory
// with one-cycle registered read latency. Reads are issued only when a slot is
// guaranteed in the 2-entry output buffer. This keeps one word per cycle under
// free flow and drops nothing under backpressure.
module wk_fetch #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned WEIGHT_BASE = 0,
  parameter int unsigned WEIGHT_SIZE = 2048,
  parameter int unsigned ROW_WORDS   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [31:0]      mem_addr,
  output logic             mem_write_en,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_row_last,
  output logic             out_last
);

  // Counters must reach WEIGHT_SIZE, so they are one bit wider than an index.
  localparam int unsigned CntW = $clog2(WEIGHT_SIZE + 1);
  localparam int unsigned RowW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam logic [CntW-1:0] LastIdx    = CntW'(WEIGHT_SIZE - 1);
  localparam logic [RowW-1:0] RowLastIdx = RowW'(ROW_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0] acc_cnt_q, acc_cnt_d;
  logic [RowW-1:0] row_cnt_q, row_cnt_d;
  logic            inflight_q, inflight_d;
  logic            done_q, done_d;
  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      occ_q, occ_d;

  logic issue;
  logic push;
  logic pop;
  logic clear;
  logic head_last;

  // Handshake and issue-credit decisions for the current cycle.
  always_comb begin
    push      = inflight_q;
    pop       = (occ_q != 2'd0) && out_ready;
    head_last = (acc_cnt_q == LastIdx);
    clear     = (state_q == StIdle) && start;
    // occ + inflight - pop < 2, rearranged to avoid unsigned underflow.
    issue     = (state_q == StFetch) &&
                (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: if (issue && (issue_cnt_q == LastIdx)) state_d = StDrain;
      StDrain: if (pop && head_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: status, read address and FIFO head.
  always_comb begin
    busy         = (state_q != StIdle);
    done         = done_q;
    mem_write_en = 1'b0;
    mem_addr     = WEIGHT_BASE + 32'(issue_cnt_q);
    out_valid    = (occ_q != 2'd0);
    out_data     = buf_q[rd_ptr_q];
    out_last     = out_valid && head_last;
    out_row_last = out_valid && (row_cnt_q == RowLastIdx);
  end

  // Issue/accept counters, in-flight tracking and done pulse.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    row_cnt_d   = row_cnt_q;
    inflight_d  = issue;
    done_d      = pop && head_last;
    if (clear) begin
      issue_cnt_d = '0;
      acc_cnt_d   = '0;
      row_cnt_d   = '0;
    end else begin
      if (issue) issue_cnt_d = issue_cnt_q + 1'b1;
      if (pop) begin
        acc_cnt_d = acc_cnt_q + 1'b1;
        row_cnt_d = (row_cnt_q == RowLastIdx) ? '0 : row_cnt_q + 1'b1;
      end
    end
  end

  // 2-entry FIFO; a push always has room because issue reserved the slot.
  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      buf_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Datapath and counter registers; reset aborts any stream in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      row_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      row_cnt_q   <= row_cnt_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      buf_q       <= buf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
    end
  end

endmodule
